decoder_hold: RTL and testbench
===============================

# decoder_hold

Sequential 3-to-8 decoder, the receive-side counterpart of the team's 8-to-3 priority-free encoder. It accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line on `y`. Each line is held for a fixed number of cycles, and a one-entry buffer allows back-to-back codes with no idle gap. The block sits downstream of encoder outputs, for example to drive strobes, LEDs or select lines from a compact code.

## Interface
- `HOLD_CYCLES`, default 4: number of cycles each decoded line stays asserted. Legal range is 1..255.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_code` is valid this cycle.
- `in_ready`  out  1: the block can accept a code this cycle.
- `in_code`  in  3: binary code 0..7.
- `y`  out  8: one-hot decoded output. All zeros when idle.
- `y_valid`  out  1: `y` holds a decoded value.
- `done`  out  1: single-cycle pulse on the last cycle of each hold window.
- `busy`  out  1: the state machine is in HOLD, or the buffer is occupied.

## Operation
- **Handshake:** a transfer occurs on a rising edge where `in_valid && in_ready`. The source must keep `in_code` stable while `in_valid=1 && in_ready=0`.
- **`in_ready`:** equals `!buf_full`. It is combinational from registered state only and never depends on `in_valid`.
- **States:** IDLE and HOLD.
- **IDLE:**
  - `y=0`, `y_valid=0`, buffer empty.
  - On a transfer, load `y <= 8'b1 << in_code`, set `cnt <= HOLD_CYCLES-1`, and go to HOLD.
- **HOLD, `cnt != 0`:**
  - `cnt` decrements and `y` is held.
  - A transfer writes the buffer, setting `buf_full=1`.
- **HOLD, `cnt == 0`** (last cycle; `done=1`). Exactly one of the following applies:
  - Buffer full: `y <= 1 << buf_code`, `cnt <= HOLD_CYCLES-1`, buffer cleared, stay in HOLD. No transfer is possible this cycle because `in_ready=0`.
  - Buffer empty and a transfer occurs: `in_code` bypasses the buffer straight to `y`, reload `cnt`, stay in HOLD.
  - Buffer empty and no transfer: `y <= 0`, `y_valid <= 0`, go to IDLE.
- **Output invariant:** `y` is always zero or exactly one-hot. `y_valid == (y != 0)`.
- **`HOLD_CYCLES=1`:** every HOLD cycle is a last cycle, so `done=1` on every valid cycle. Codes stream at 1 per cycle with bypass. The buffer fills only if the source is stalled, which cannot happen, so it stays empty.
- **Widths:** `cnt` is 8 bits. `HOLD_CYCLES-1` is computed at elaboration.
- **Reset:** if `rst` is seen mid-hold, the pending code, the buffer and the counter are all discarded.

## Timing
- Reset values: `y=8'h00`, `y_valid=0`, `done=0`, `busy=0`, `in_ready=1`. State is IDLE, `cnt=0`, `buf_full=0`.
- Latency: a code transferred at edge k appears on `y` after edge k. It stays for exactly `HOLD_CYCLES` cycles, i.e. edges k..k+HOLD_CYCLES-1 launch the same value.
- Back-to-back codes: the following code appears in the cycle immediately after the previous window's last cycle. There is no zero cycle between them.
- Gap case: `y` returns to 0 one cycle after a last cycle that has neither a buffered nor a bypassed code.
- `done`, `busy` and `in_ready` are combinational from registered state.
- `done` is decoded from HOLD && `cnt==0`.
- Throughput: 1 code per `HOLD_CYCLES` cycles.

## Structure
- Shared package `decoder_pkg` holds:
  - state encoding localparams: `ST_IDLE=1'b0`, `ST_HOLD=1'b1`;
  - `CODE_W=3`;
  - `ONEHOT_W=8`.
- One natural sub-module, `hold_counter`:
  - ports: `clk`, `rst`, `load`, `load_val[7:0]`, `zero`;
  - loadable down-counter that saturates at 0.
- The decode itself (`1 << code`) stays inline. The top level owns the FSM and the 1-entry buffer (`buf_code[2:0]`, `buf_full`).

## Test plan
- Reset check: assert `rst` for 2 cycles, then release. Expect `y=0`, `y_valid=0`, `in_ready=1`, `done=0`.
- Single code, `HOLD_CYCLES=4`: send code 5 once. Expect `y=8'h20` for exactly 4 cycles, `done` high on the 4th cycle only, then `y=0`.
- Back-to-back buffering: send 2, then 7 while the first hold is in progress. Expect `y=8'h04` for 4 cycles, then `8'h80` for 4 cycles with no gap. `in_ready` is 0 from the buffer write until the buffer drains.
- Bypass: with `in_valid` asserted only on the last hold cycle of code 0, send code 3. Expect `y=8'h01` followed immediately by `y=8'h08`, and the buffer never fills.
- `HOLD_CYCLES=1` stream: send 0..7 on consecutive cycles. Expect `y=8'h01,02,...,80` on consecutive cycles, with `done` high throughout.
- Reset mid-hold: with code 6 held and code 1 buffered, assert `rst`. Expect `y=0` and `in_ready=1` next cycle, and code 1 never appears.

Source files
------------

// File: rtl/decoder_hold_pkg.sv
// decoder_pkg: shared definitions for the decoder_hold slice.
//   ST_IDLE / ST_HOLD : FSM state encoding (1 bit)
//   CODE_W            : width of the binary code accepted on the input
//   ONEHOT_W          : width of the decoded one-hot output
package decoder_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

endpackage

// File: rtl/decoder_hold_hold_counter.sv
// hold_counter: loadable 8-bit down-counter that saturates at zero.
//   clk      in  : clock, rising edge
//   rst      in  : synchronous active-high reset, clears the count
//   load     in  : load load_val this cycle (takes priority over counting)
//   load_val in  : value to load
//   zero     out : count is zero (combinational from the count register)
module hold_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt_reg;
  logic [7:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (cnt_reg != 8'd0) begin
      cnt_next = cnt_reg - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 8'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign zero = (cnt_reg == 8'd0);

endmodule

// File: rtl/decoder_hold.sv
// decoder_hold: sequential 3-to-8 decoder with a fixed hold window per code
// and a one-entry buffer so consecutive codes follow with no idle gap.
//   HOLD_CYCLES : cycles each decoded line stays asserted (1..255)
//   clk, rst    : clock (rising edge), synchronous active-high reset
//   in_valid    : in_code is valid this cycle
//   in_ready    : a code can be accepted this cycle (buffer not full)
//   in_code     : binary code 0..7
//   y           : one-hot decoded line, zero when idle
//   y_valid     : y holds a decoded value
//   done        : pulse on the last cycle of each hold window
//   busy        : holding a code or the buffer is occupied
module decoder_hold
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in_code,
  output logic [ONEHOT_W-1:0] y,
  output logic                y_valid,
  output logic                done,
  output logic                busy
);

  // Counter reload: the window covers the load cycle plus HOLD_CYCLES-1 more.
  localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

  logic                state_reg;
  logic                state_next;
  logic [ONEHOT_W-1:0] y_reg;
  logic [ONEHOT_W-1:0] y_next;
  logic [CODE_W-1:0]   buf_code_reg;
  logic [CODE_W-1:0]   buf_code_next;
  logic                buf_full_reg;
  logic                buf_full_next;
  logic                cnt_load;
  logic                cnt_zero;
  logic                xfer;

  hold_counter u_hold_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (RELOAD),
    .zero     (cnt_zero)
  );

  // in_ready depends only on registered state, so xfer has no comb loop.
  assign xfer = in_valid && in_ready;

  // State register, decoded output register and the one-entry buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      y_reg        <= '0;
      buf_code_reg <= '0;
      buf_full_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      y_reg        <= y_next;
      buf_code_reg <= buf_code_next;
      buf_full_reg <= buf_full_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next    = state_reg;
    y_next        = y_reg;
    buf_code_next = buf_code_reg;
    buf_full_next = buf_full_reg;
    cnt_load      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (xfer) begin
          y_next     = ONEHOT_W'(1) << in_code;
          cnt_load   = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!cnt_zero) begin
          // Mid-window arrivals park in the buffer until the window ends.
          if (xfer) begin
            buf_code_next = in_code;
            buf_full_next = 1'b1;
          end
        end else if (buf_full_reg) begin
          // Last cycle with a parked code: in_ready is low, so no xfer here.
          y_next        = ONEHOT_W'(1) << buf_code_reg;
          cnt_load      = 1'b1;
          buf_full_next = 1'b0;
        end else if (xfer) begin
          // Last cycle with empty buffer: new code goes straight to y.
          y_next   = ONEHOT_W'(1) << in_code;
          cnt_load = 1'b1;
        end else begin
          y_next     = '0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        y_next        = '0;
        buf_full_next = 1'b0;
      end
    endcase
  end

  // Outputs, all from registered state.
  always_comb begin
    in_ready = !buf_full_reg;
    done     = (state_reg == ST_HOLD) && cnt_zero;
    busy     = (state_reg == ST_HOLD) || buf_full_reg;
    y        = y_reg;
    y_valid  = (state_reg == ST_HOLD);
  end

endmodule

// File: tb/tb_decoder_hold.sv
// tb_decoder_hold: self-checking bench for decoder_hold.
// Two instances (HOLD_CYCLES=4 and HOLD_CYCLES=1) share the reset; one is
// driven at a time. The reference model is a schedule: each accepted code
// gets a start edge = max(accept edge, previous start + H), and every output
// at edge t is derived from that list of windows.
module tb_decoder_hold;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv4 = 1'b0;
  logic [2:0] ic4 = 3'd0;
  logic       iv1 = 1'b0;
  logic [2:0] ic1 = 3'd0;
  logic       r4, yv4, d4, b4;
  logic       r1, yv1, d1, b1;
  logic [7:0] y4, y1;

  always #5 clk = ~clk;

  decoder_hold #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(r4), .in_code(ic4),
    .y(y4), .y_valid(yv4), .done(d4), .busy(b4)
  );

  decoder_hold #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(r1), .in_code(ic1),
    .y(y1), .y_valid(yv1), .done(d1), .busy(b1)
  );

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  bit sel1 = 1'b0;
  int cur_h = 4;
  int acc_q[$];
  int start_q[$];
  int code_q[$];

  always @(posedge clk) edge_n <= edge_n + 1;

  logic [7:0] oy;
  logic       ov, od, ob, orr;
  assign oy  = sel1 ? y1  : y4;
  assign ov  = sel1 ? yv1 : yv4;
  assign od  = sel1 ? d1  : d4;
  assign ob  = sel1 ? b1  : b4;
  assign orr = sel1 ? r1  : r4;

  // ---------------- reference model (schedule of hold windows) -----------
  function automatic bit m_full(int t);
    foreach (acc_q[i])
      if (acc_q[i] <= t && start_q[i] > t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_y(int t);
    foreach (start_q[i])
      if (start_q[i] <= t && t < start_q[i] + cur_h) return 8'(2 ** code_q[i]);
    return 8'h00;
  endfunction

  function automatic bit m_done(int t);
    foreach (start_q[i])
      if (t == start_q[i] + cur_h - 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // One clock: drive at the negedge, model the edge, check at the next negedge.
  task automatic step(input bit v, input int code, input bit r, output bit xf);
    int k;
    int s;
    int t;
    logic [7:0] ey;
    rst = r;
    if (sel1) begin iv1 = v; ic1 = 3'(code); end
    else      begin iv4 = v; ic4 = 3'(code); end
    xf = v && !r && !m_full(edge_n);
    k  = edge_n + 1;
    @(posedge clk);
    if (r) begin
      acc_q.delete(); start_q.delete(); code_q.delete();
    end else if (xf) begin
      s = k;
      if (start_q.size() > 0 && start_q[$] + cur_h > s) s = start_q[$] + cur_h;
      acc_q.push_back(k); start_q.push_back(s); code_q.push_back(code);
      $display("[TB] H=%0d xfer code=%0d at edge %0d, window starts edge %0d", cur_h, code, k, s);
    end
    @(negedge clk);
    t  = edge_n;
    ey = m_y(t);
    chk("y",        oy,           ey);
    chk("y_valid",  {7'd0, ov},   {7'd0, ey != 8'h00});
    chk("done",     {7'd0, od},   {7'd0, m_done(t)});
    chk("busy",     {7'd0, ob},   {7'd0, (ey != 8'h00) || m_full(t)});
    chk("in_ready", {7'd0, orr},  {7'd0, !m_full(t)});
  endtask

  task automatic idle(input int n);
    bit xf;
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, xf);
  endtask

  // Random traffic honouring the stability rule while stalled.
  task automatic rand_run(input int n);
    bit xf;
    bit hold = 1'b0;
    bit v;
    bit r;
    int c = 0;
    for (int i = 0; i < n; i++) begin
      if (hold) begin
        v = 1'b1;
      end else begin
        v = ($urandom_range(0, 99) < 55);
        c = $urandom_range(0, 7);
      end
      r = ($urandom_range(0, 199) == 0);
      step(v, c, r, xf);
      hold = v && !xf && !r;
    end
  endtask

  initial begin
    bit xf;

    // Reset for two cycles, then check the idle outputs.
    step(1'b0, 0, 1'b1, xf);
    step(1'b0, 0, 1'b1, xf);
    chk("rst_y", oy, 8'h00);
    chk("rst_in_ready", {7'd0, orr}, 8'h01);
    chk("rst_done", {7'd0, od}, 8'h00);
    idle(1);

    // Single code 5: 0x20 for four cycles, done on the fourth only.
    step(1'b1, 5, 1'b0, xf);
    chk("single_y_first", oy, 8'h20);
    idle(3);
    chk("single_done_last", {7'd0, od}, 8'h01);
    idle(2);
    chk("single_y_after", oy, 8'h00);

    // Back-to-back: 2 then 7 buffered mid-window, no gap between them.
    step(1'b1, 2, 1'b0, xf);
    step(1'b1, 7, 1'b0, xf);
    chk("b2b_y_first", oy, 8'h04);
    chk("b2b_ready_low", {7'd0, orr}, 8'h00);
    idle(2);
    step(1'b0, 0, 1'b0, xf);
    chk("b2b_y_second", oy, 8'h80);
    idle(5);

    // Bypass: code 3 arrives exactly on the last cycle of code 0.
    step(1'b1, 0, 1'b0, xf);
    idle(3);
    step(1'b1, 3, 1'b0, xf);
    chk("bypass_y", oy, 8'h08);
    chk("bypass_ready", {7'd0, orr}, 8'h01);
    idle(5);

    // Reset mid-hold with 6 held and 1 buffered; code 1 must never show.
    step(1'b1, 6, 1'b0, xf);
    step(1'b1, 1, 1'b0, xf);
    step(1'b0, 0, 1'b1, xf);
    chk("midrst_y", oy, 8'h00);
    chk("midrst_ready", {7'd0, orr}, 8'h01);
    idle(6);

    rand_run(300);

    // Switch to the HOLD_CYCLES=1 instance.
    iv4   = 1'b0;
    sel1  = 1'b1;
    cur_h = 1;
    step(1'b0, 0, 1'b1, xf);
    step(1'b0, 0, 1'b1, xf);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, c, 1'b0, xf);
      chk("stream_y", oy, 8'(2 ** c));
      chk("stream_done", {7'd0, od}, 8'h01);
    end
    idle(2);
    rand_run(150);
    iv1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
